// File: rtl/correlator_pkg.sv
// Shared constants for the coincidence correlator: register map, ID, FSM encoding, counter layout.
package correlator_pkg;

   localparam int CNT_W = 16;

   localparam logic [7:0] ID_VALUE      = 8'hC0;
   localparam logic [6:0] ADDR_ID       = 7'h00;
   localparam logic [6:0] ADDR_WEXP     = 7'h01;
   localparam logic [6:0] ADDR_STATUS   = 7'h02;
   localparam logic [6:0] ADDR_CTRL     = 7'h03;
   localparam logic [6:0] ADDR_CNT_BASE = 7'h10;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_WR_DATA  = 2'd1;
   localparam logic [1:0] ST_RD_REPLY = 2'd2;

   typedef struct packed {
      logic [CNT_W-1:0] x;
      logic [CNT_W-1:0] y;
      logic [CNT_W-1:0] isect;
      logic [CNT_W-1:0] symdiff;
   } counts_t;

endpackage

// File: rtl/correlator_if.sv
// Byte-serial BytePipe link; slave is the device, master is the host.
interface correlator_if;
   logic [7:0] i_bp_data;
   logic       i_bp_valid;
   logic       o_bp_ready;
   logic [7:0] o_bp_data;
   logic       o_bp_valid;
   logic       i_bp_ready;

   modport slave (
      input  i_bp_data, i_bp_valid, i_bp_ready,
      output o_bp_ready, o_bp_data, o_bp_valid
   );

   modport master (
      output i_bp_data, i_bp_valid, i_bp_ready,
      input  o_bp_ready, o_bp_data, o_bp_valid
   );
endinterface

// File: rtl/bp_reg_fsm.sv
// BytePipe command decoder: turns cmd/data bytes into register write/read strobes and
// returns one reply byte per read, one enabled cycle after the command is accepted.
module bp_reg_fsm
   import correlator_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_cg,
   correlator_if.slave bp,
   output logic        wr_en,
   output logic [6:0]  wr_addr,
   output logic [7:0]  wr_data,
   output logic        rd_en,
   output logic [6:0]  rd_addr,
   input  logic [7:0]  rd_data
);

   logic [1:0] state;
   logic [6:0] addr_q;
   logic       up_xfer;

   assign bp.o_bp_ready = (state == ST_IDLE) || (state == ST_WR_DATA);
   assign up_xfer       = i_cg && bp.i_bp_valid && bp.o_bp_ready;

   assign wr_en   = up_xfer && (state == ST_WR_DATA);
   assign wr_addr = addr_q;
   assign wr_data = bp.i_bp_data;
   assign rd_en   = up_xfer && (state == ST_IDLE) && !bp.i_bp_data[7];
   assign rd_addr = bp.i_bp_data[6:0];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= ST_IDLE;
         addr_q        <= '0;
         bp.o_bp_valid <= 1'b0;
         bp.o_bp_data  <= '0;
      end else if (i_cg) begin
         case (state)
            ST_IDLE: begin
               if (bp.i_bp_valid) begin
                  if (bp.i_bp_data[7]) begin
                     addr_q <= bp.i_bp_data[6:0];
                     state  <= ST_WR_DATA;
                  end else begin
                     bp.o_bp_data  <= rd_data;
                     bp.o_bp_valid <= 1'b1;
                     state         <= ST_RD_REPLY;
                  end
               end
            end
            ST_WR_DATA: begin
               if (bp.i_bp_valid) state <= ST_IDLE;
            end
            ST_RD_REPLY: begin
               // reply byte stays on the bus until the host takes it
               if (bp.i_bp_ready) begin
                  bp.o_bp_valid <= 1'b0;
                  state         <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/correlator_core.sv
// Coincidence counter for two event streams over 2^windowExp enabled cycles,
// with BytePipe register access and an atomic snapshot of the 8 result bytes.
module correlator_core
   import correlator_pkg::*;
#(
   parameter int MAX_WINDOW_EXP     = 15,
   parameter int DEFAULT_WINDOW_EXP = 8
)(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_cg,
   input  logic        i_x,
   input  logic        i_y,
   correlator_if.slave bp
);

   logic       wr_en, rd_en;
   logic [6:0] wr_addr, rd_addr;
   logic [7:0] wr_data, rd_data;

   bp_reg_fsm u_fsm (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_cg    (i_cg),
      .bp      (bp),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   counts_t          acc, res, shadow, acc_next;
   logic [CNT_W-1:0] t, t_last;
   logic [7:0]       window_exp, wexp_clamped;
   logic             enable, result_valid;
   logic             cfg_wr, snap;

   always_comb begin
      acc_next.x       = acc.x       + CNT_W'(i_x);
      acc_next.y       = acc.y       + CNT_W'(i_y);
      acc_next.isect   = acc.isect   + CNT_W'(i_x & i_y);
      acc_next.symdiff = acc.symdiff + CNT_W'(i_x ^ i_y);
   end

   assign t_last = (CNT_W'(1) << window_exp) - CNT_W'(1);
   assign wexp_clamped = (wr_data == 8'd0)                 ? 8'd1 :
                         (wr_data > 8'(MAX_WINDOW_EXP))    ? 8'(MAX_WINDOW_EXP) : wr_data;
   assign cfg_wr = wr_en && ((wr_addr == ADDR_WEXP) || (wr_addr == ADDR_CTRL));
   assign snap   = rd_en && (rd_addr == ADDR_CNT_BASE);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc          <= '0;
         res          <= '0;
         shadow       <= '0;
         t            <= '0;
         window_exp   <= 8'(DEFAULT_WINDOW_EXP);
         enable       <= 1'b1;
         result_valid <= 1'b0;
      end else if (i_cg) begin
         if (snap) shadow <= res;
         if (wr_en && (wr_addr == ADDR_WEXP)) window_exp <= wexp_clamped;
         if (wr_en && (wr_addr == ADDR_CTRL)) enable     <= wr_data[0];
         // a config write restarts the window and beats a coincident window end
         if (cfg_wr) begin
            acc          <= '0;
            t            <= '0;
            result_valid <= 1'b0;
         end else if (enable) begin
            if (t == t_last) begin
               res          <= acc_next;
               acc          <= '0;
               t            <= '0;
               result_valid <= 1'b1;
            end else begin
               acc <= acc_next;
               t   <= t + CNT_W'(1);
            end
         end
      end
   end

   // 0x10 replies straight from the results (the value being snapshotted); 0x11-0x17 from the snapshot
   always_comb begin
      rd_data = 8'h00;
      case (rd_addr)
         ADDR_ID:     rd_data = ID_VALUE;
         ADDR_WEXP:   rd_data = window_exp;
         ADDR_STATUS: rd_data = {7'd0, result_valid};
         ADDR_CTRL:   rd_data = {7'd0, enable};
         7'h10:       rd_data = res.x[15:8];
         7'h11:       rd_data = shadow.x[7:0];
         7'h12:       rd_data = shadow.y[15:8];
         7'h13:       rd_data = shadow.y[7:0];
         7'h14:       rd_data = shadow.isect[15:8];
         7'h15:       rd_data = shadow.isect[7:0];
         7'h16:       rd_data = shadow.symdiff[15:8];
         7'h17:       rd_data = shadow.symdiff[7:0];
         default:     rd_data = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_correlator_core.sv
// Randomized bench for correlator_core against a window-sum reference model.
module tb_correlator_core;

   logic clk = 1'b0;
   logic rst, cg, x, y;
   correlator_if bp ();

   correlator_core #(.MAX_WINDOW_EXP(15), .DEFAULT_WINDOW_EXP(8)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .i_cg  (cg),
      .i_x   (x),
      .i_y   (y),
      .bp    (bp)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // reference model: keeps the raw samples of the current window and sums them when it fills
   int       m_wexp;
   bit       m_en, m_rv;
   bit [1:0] m_q[$];
   int       m_res[4];
   int       m_shadow[4];
   bit       f_wr, f_snap;
   int       f_wr_addr, f_wr_data;
   int       xy_mode = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_wexp = 8; m_en = 1; m_rv = 0; m_q.delete();
         for (int i = 0; i < 4; i++) begin m_res[i] = 0; m_shadow[i] = 0; end
      end else if (cg) begin
         if (f_snap) m_shadow = m_res;
         if (f_wr && (f_wr_addr == 1 || f_wr_addr == 3)) begin
            if (f_wr_addr == 1) m_wexp = (f_wr_data < 1) ? 1 : (f_wr_data > 15) ? 15 : f_wr_data;
            else                m_en   = f_wr_data[0];
            m_q.delete();
            m_rv = 0;
         end else if (m_en) begin
            m_q.push_back({x, y});
            if (m_q.size() == (1 << m_wexp)) begin
               for (int i = 0; i < 4; i++) m_res[i] = 0;
               foreach (m_q[i]) begin
                  m_res[0] += int'(m_q[i][1]);
                  m_res[1] += int'(m_q[i][0]);
                  m_res[2] += int'(m_q[i][1] & m_q[i][0]);
                  m_res[3] += int'(m_q[i][1] ^ m_q[i][0]);
               end
               m_q.delete();
               m_rv = 1;
            end
         end
      end
   end

   function automatic logic [7:0] exp_reg(input int a);
      int v;
      if (a == 0) return 8'hC0;
      if (a == 1) return 8'(m_wexp);
      if (a == 2) return {7'd0, m_rv};
      if (a == 3) return {7'd0, m_en};
      if (a == 16) return 8'(m_res[0] >> 8);
      if (a >= 17 && a <= 23) begin
         v = m_shadow[(a - 16) / 2];
         return (a % 2 == 0) ? 8'(v >> 8) : 8'(v);
      end
      return 8'h00;
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (xy_mode == 2) begin
            x = 1'($urandom_range(0, 1));
            y = 1'($urandom_range(0, 1));
         end
      end
   end

   task automatic write_reg(input logic [6:0] a, input logic [7:0] d);
      @(negedge clk);
      bp.i_bp_valid = 1'b1; bp.i_bp_data = {1'b1, a};
      @(negedge clk);
      bp.i_bp_data = d; f_wr = 1; f_wr_addr = int'(a); f_wr_data = int'(d);
      @(negedge clk);
      bp.i_bp_valid = 1'b0; f_wr = 0;
   endtask

   task automatic read_reg(input logic [6:0] a, input int stall, output logic [7:0] val);
      logic [7:0] e;
      @(negedge clk);
      bp.i_bp_valid = 1'b1; bp.i_bp_data = {1'b0, a};
      bp.i_bp_ready = (stall == 0);
      e = exp_reg(int'(a));
      f_snap = (a == 7'h10);
      @(negedge clk);
      bp.i_bp_valid = 1'b0; f_snap = 0;
      val = bp.o_bp_data;
      check("rd_vld", 32'(bp.o_bp_valid), 32'd1);
      check($sformatf("rd_%02h", a), 32'(bp.o_bp_data), 32'(e));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("stall_vld", 32'(bp.o_bp_valid), 32'd1);
         check("stall_dat", 32'(bp.o_bp_data), 32'(e));
         check("stall_rdy", 32'(bp.o_bp_ready), 32'd0);
      end
      bp.i_bp_ready = 1'b1;
      @(negedge clk);
      check("post_vld", 32'(bp.o_bp_valid), 32'd0);
      check("post_rdy", 32'(bp.o_bp_ready), 32'd1);
   endtask

   task automatic read_counts(input int stall, output int c[4]);
      logic [7:0] hi, lo;
      for (int k = 0; k < 4; k++) begin
         read_reg(7'(16 + 2 * k), stall, hi);
         read_reg(7'(17 + 2 * k), stall, lo);
         c[k] = int'({hi, lo});
      end
   endtask

   initial begin
      logic [7:0] v;
      int c[4];
      rst = 1; cg = 1; x = 0; y = 0; f_wr = 0; f_snap = 0;
      bp.i_bp_valid = 0; bp.i_bp_data = 0; bp.i_bp_ready = 1;
      repeat (3) @(negedge clk);
      rst = 0;
      check("rst_vld", 32'(bp.o_bp_valid), 32'd0);
      check("rst_dat", 32'(bp.o_bp_data), 32'd0);
      check("rst_rdy", 32'(bp.o_bp_ready), 32'd1);

      read_reg(7'h00, 0, v);
      check("id", 32'(v), 32'hC0);
      read_reg(7'h02, 0, v);

      // 4-cycle window, x only
      x = 1; y = 0;
      write_reg(7'h01, 8'h02);
      repeat (6) @(negedge clk);
      read_counts(0, c);
      check("t2_x", 32'(c[0]), 32'd4);
      check("t2_y", 32'(c[1]), 32'd0);
      check("t2_i", 32'(c[2]), 32'd0);
      check("t2_s", 32'(c[3]), 32'd4);
      read_reg(7'h02, 0, v);
      check("t2_rv", 32'(v), 32'd1);

      // 16-cycle window, both streams high
      x = 1; y = 1;
      write_reg(7'h01, 8'h04);
      repeat (18) @(negedge clk);
      read_counts(0, c);
      check("t3_x", 32'(c[0]), 32'd16);
      check("t3_y", 32'(c[1]), 32'd16);
      check("t3_i", 32'(c[2]), 32'd16);
      check("t3_s", 32'(c[3]), 32'd0);

      // clamping
      write_reg(7'h01, 8'h00);
      read_reg(7'h01, 0, v);
      check("clamp_lo", 32'(v), 32'd1);
      write_reg(7'h01, 8'h14);
      read_reg(7'h01, 0, v);
      check("clamp_hi", 32'(v), 32'd15);

      // long reply stall
      read_reg(7'h00, 10, v);

      // clock gate held low mid-window with a command pending
      write_reg(7'h01, 8'h03);
      x = 1; y = 0;
      repeat (3) @(negedge clk);
      cg = 0; bp.i_bp_valid = 1; bp.i_bp_data = 8'h00;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("cg_vld", 32'(bp.o_bp_valid), 32'd0);
         check("cg_rdy", 32'(bp.o_bp_ready), 32'd1);
      end
      bp.i_bp_valid = 0; cg = 1;
      repeat (12) @(negedge clk);
      read_counts(0, c);
      check("t6_x", 32'(c[0]), 32'd8);

      // reset while a reply is pending
      @(negedge clk);
      bp.i_bp_valid = 1; bp.i_bp_data = 8'h00; bp.i_bp_ready = 0;
      @(negedge clk);
      bp.i_bp_valid = 0;
      check("mid_vld", 32'(bp.o_bp_valid), 32'd1);
      rst = 1;
      @(negedge clk);
      rst = 0; bp.i_bp_ready = 1;
      check("mid_rst_vld", 32'(bp.o_bp_valid), 32'd0);
      check("mid_rst_rdy", 32'(bp.o_bp_ready), 32'd1);
      read_reg(7'h01, 0, v);

      // randomized traffic
      xy_mode = 2;
      write_reg(7'h01, 8'h02);
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 5))
            0: write_reg(7'h01, 8'($urandom_range(0, 5)));
            1: write_reg(7'h03, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'h01);
            2: read_counts($urandom_range(0, 3), c);
            3: read_reg(7'($urandom_range(0, 3)), $urandom_range(0, 2), v);
            4: read_reg(7'($urandom_range(4, 127)), 0, v);
            default: write_reg(($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20, 8'($urandom));
         endcase
         repeat ($urandom_range(0, 10)) @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
